// File: rtl/mem_arbiter_n_pkg.sv
// Shared types and constants for the N-channel memory arbiter.
package mem_arbiter_n_pkg;

    localparam int unsigned MEMORY_WIDTH    = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned OWNER_W         = 3;
    localparam int unsigned TMO_W           = 16;

    localparam int unsigned MODE_FIXED      = 0;
    localparam int unsigned MODE_RR         = 1;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    // Direction and address of the request selected for the memory port.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_n_rr_picker.sv
// Combinational winner selection: lowest index (fixed) or first set index
// after base, wrapping modulo NCH (round-robin).
module rr_picker #(
    parameter int unsigned NCH = 2,
    parameter int unsigned IW  = 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  base,
    input  logic           mode_rr,
    output logic [IW-1:0]  winner_c,
    output logic           found_c
);

    localparam int unsigned CW = IW + 1;

    logic [CW-1:0] cand;

    // Scan candidates in priority order; the first requesting one wins.
    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = mode_rr ? (CW'(base) + CW'(k) + CW'(1)) : CW'(k);
            if (cand >= CW'(NCH)) begin
                cand = cand - CW'(NCH);
            end
            if (!found_c && req[cand[IW-1:0]]) begin
                found_c  = 1'b1;
                winner_c = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// NCH-channel arbiter sharing one synchronous memory port; one access in
// flight. Optional ack watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter_n
    import mem_arbiter_n_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned WIDTH   = MEMORY_WIDTH,
    parameter int unsigned MODE    = MODE_RR,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH-1:0]          ch_rw,
    input  logic [NCH*ADDR_W-1:0]   ch_addr,
    input  logic [NCH*WIDTH-1:0]    ch_wdata,
    output logic [NCH-1:0]          ch_ack,
    output logic                    ch_err,
    output logic [WIDTH-1:0]        ch_rdata,
    output logic [OWNER_W-1:0]      owner,
    output logic                    mem_enable,
    output logic                    mem_rw,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WIDTH-1:0]        mem_data_in,
    input  logic [WIDTH-1:0]        mem_data_out,
    input  logic                    mem_ack
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    // Reject unsupported configurations at elaboration.
    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("mem_arbiter_n: NCH must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mem_arbiter_n: TIMEOUT must be 1..65535");
    end

    arb_state_e         state_q, state_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               mem_enable_q, mem_enable_d;
    logic               mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]   mem_data_in_q, mem_data_in_d;
    logic [WIDTH-1:0]   ch_rdata_q, ch_rdata_d;
    logic [NCH-1:0]     ch_ack_q, ch_ack_d;
`ifdef ARB_TIMEOUT_EN
    logic               ch_err_q, ch_err_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
`endif

    logic [IW-1:0]      win_c;
    logic               found_c;
    mem_cmd_t           sel_cmd;
    logic [WIDTH-1:0]   sel_wdata;
    logic [NCH-1:0]     owner_onehot;

    rr_picker #(
        .NCH (NCH),
        .IW  (IW)
    ) u_picker (
        .req      (ch_req),
        .base     (rr_ptr_q),
        .mode_rr  (MODE == MODE_RR),
        .winner_c (win_c),
        .found_c  (found_c)
    );

    // Route the winning channel's command and write data, and decode the owner.
    always_comb begin
        sel_cmd      = '0;
        sel_wdata    = '0;
        owner_onehot = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (IW'(i) == win_c) begin
                sel_cmd.rw   = ch_rw[i];
                sel_cmd.addr = ch_addr[ADDR_W*i +: ADDR_W];
                sel_wdata    = ch_wdata[WIDTH*i +: WIDTH];
            end
            owner_onehot[i] = (OWNER_W'(i) == owner_q);
        end
    end

    // Next-state and registered-output logic for IDLE -> BUSY -> DONE.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        mem_enable_d  = mem_enable_q;
        mem_rw_d      = mem_rw_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        ch_rdata_d    = ch_rdata_q;
        ch_ack_d      = '0;
`ifdef ARB_TIMEOUT_EN
        ch_err_d      = 1'b0;
        timer_d       = timer_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (found_c) begin
                    state_d       = ARB_BUSY;
                    owner_d       = OWNER_W'(win_c);
                    rr_ptr_d      = win_c;
                    mem_enable_d  = 1'b1;
                    mem_rw_d      = sel_cmd.rw;
                    mem_addr_d    = sel_cmd.addr;
                    mem_data_in_d = sel_wdata;
`ifdef ARB_TIMEOUT_EN
                    timer_d       = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    if (mem_rw_q) begin
                        ch_rdata_d = mem_data_out;
                    end
                    mem_enable_d = 1'b0;
                    ch_ack_d     = owner_onehot;
                    state_d      = ARB_DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (timer_q == TMO_W'(TIMEOUT - 1)) begin
                    mem_enable_d = 1'b0;
                    ch_rdata_d   = '0;
                    ch_ack_d     = owner_onehot;
                    ch_err_d     = 1'b1;
                    state_d      = ARB_DONE;
                end else begin
                    timer_d = timer_q + TMO_W'(1);
                end
`endif
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= IW'(NCH - 1);
            mem_enable_q  <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            ch_rdata_q    <= '0;
            ch_ack_q      <= '0;
`ifdef ARB_TIMEOUT_EN
            ch_err_q      <= 1'b0;
            timer_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            mem_enable_q  <= mem_enable_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            ch_rdata_q    <= ch_rdata_d;
            ch_ack_q      <= ch_ack_d;
`ifdef ARB_TIMEOUT_EN
            ch_err_q      <= ch_err_d;
            timer_q       <= timer_d;
`endif
        end
    end

    assign owner       = owner_q;
    assign mem_enable  = mem_enable_q;
    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign ch_rdata    = ch_rdata_q;
    assign ch_ack      = ch_ack_q;
`ifdef ARB_TIMEOUT_EN
    assign ch_err      = ch_err_q;
`else
    assign ch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: a round-robin and a fixed-priority
// instance, NCH=4, TIMEOUT=8; inputs driven and outputs sampled on negedge.
module tb_mem_arbiter_n;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance
    logic [NCH-1:0]    r_req, r_rw, r_ack;
    logic [NCH*32-1:0] r_addr;
    logic [NCH*W-1:0]  r_wdata;
    logic              r_err, r_men, r_mrw, r_mack;
    logic [W-1:0]      r_rdata, r_mdin, r_mdout;
    logic [2:0]        r_owner;
    logic [31:0]       r_maddr;

    // Fixed-priority instance
    logic [NCH-1:0]    f_req, f_rw, f_ack;
    logic [NCH*32-1:0] f_addr;
    logic [NCH*W-1:0]  f_wdata;
    logic              f_err, f_men, f_mrw, f_mack;
    logic [W-1:0]      f_rdata, f_mdin, f_mdout;
    logic [2:0]        f_owner;
    logic [31:0]       f_maddr;

    int checks = 0;
    int errors = 0;

    mem_arbiter_n #(.NCH(NCH), .WIDTH(W), .MODE(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .reset(reset),
        .ch_req(r_req), .ch_rw(r_rw), .ch_addr(r_addr), .ch_wdata(r_wdata),
        .ch_ack(r_ack), .ch_err(r_err), .ch_rdata(r_rdata), .owner(r_owner),
        .mem_enable(r_men), .mem_rw(r_mrw), .mem_addr(r_maddr), .mem_data_in(r_mdin),
        .mem_data_out(r_mdout), .mem_ack(r_mack)
    );

    mem_arbiter_n #(.NCH(NCH), .WIDTH(W), .MODE(0), .TIMEOUT(8)) u_fx (
        .clk(clk), .reset(reset),
        .ch_req(f_req), .ch_rw(f_rw), .ch_addr(f_addr), .ch_wdata(f_wdata),
        .ch_ack(f_ack), .ch_err(f_err), .ch_rdata(f_rdata), .owner(f_owner),
        .mem_enable(f_men), .mem_rw(f_mrw), .mem_addr(f_maddr), .mem_data_in(f_mdin),
        .mem_data_out(f_mdout), .mem_ack(f_mack)
    );

    // Pulse reset for two cycles, ending on a negedge.
    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        r_req = '0; r_rw = '0; r_addr = '0; r_wdata = '0; r_mack = 1'b0; r_mdout = '0;
        f_req = '0; f_rw = '0; f_addr = '0; f_wdata = '0; f_mack = 1'b0; f_mdout = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (r_ack !== 4'b0 || r_err !== 1'b0 || r_rdata !== 32'h0 || r_owner !== 3'd0 ||
            r_men !== 1'b0 || r_mrw !== 1'b0 || r_maddr !== 32'h0 || r_mdin !== 32'h0) begin
            errors++;
            $display("FAIL reset_rr ack=%b err=%b rdata=%h owner=%0d men=%b mrw=%b maddr=%h mdin=%h want all zero",
                     r_ack, r_err, r_rdata, r_owner, r_men, r_mrw, r_maddr, r_mdin);
        end
        checks++;
        if (f_ack !== 4'b0 || f_err !== 1'b0 || f_rdata !== 32'h0 || f_owner !== 3'd0 ||
            f_men !== 1'b0 || f_maddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_fixed ack=%b err=%b rdata=%h owner=%0d men=%b maddr=%h want all zero",
                     f_ack, f_err, f_rdata, f_owner, f_men, f_maddr);
        end
        reset = 1'b1;
        r_mack = 1'b1;
        @(negedge clk);
        r_mack = 1'b0;
        checks++;
        if (r_men !== 1'b0 || r_ack !== 4'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored men=%b ack=%b want 0 0000", r_men, r_ack);
        end
    endtask

    task automatic test_single_read();
        r_addr[31:0] = 32'h40;
        r_rw = 4'b0001;
        r_req = 4'b0001;
        @(negedge clk);
        checks++;
        if (r_men !== 1'b1 || r_maddr !== 32'h40 || r_mrw !== 1'b1 || r_owner !== 3'd0) begin
            errors++;
            $display("FAIL read_grant men=%b maddr=%h mrw=%b owner=%0d want 1 00000040 1 0",
                     r_men, r_maddr, r_mrw, r_owner);
        end
        @(negedge clk);
        checks++;
        if (r_men !== 1'b1 || r_ack !== 4'b0) begin
            errors++;
            $display("FAIL read_wait men=%b ack=%b want 1 0000", r_men, r_ack);
        end
        r_mack = 1'b1;
        r_mdout = 32'hCAFE0001;
        @(negedge clk);
        r_mack = 1'b0;
        r_req = '0;
        checks++;
        if (r_ack !== 4'b0001 || r_rdata !== 32'hCAFE0001 || r_men !== 1'b0 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL read_done ack=%b rdata=%h men=%b err=%b want 0001 cafe0001 0 0",
                     r_ack, r_rdata, r_men, r_err);
        end
        @(negedge clk);
        checks++;
        if (r_ack !== 4'b0) begin
            errors++;
            $display("FAIL read_ack_pulse ack=%b want 0000", r_ack);
        end
    endtask

    task automatic test_rr_order();
        int unsigned exp_ch;
        int n;
        logic [3:0] exp_ack;
        pulse_reset();
        for (int i = 0; i < 4; i++) r_addr[32*i +: 32] = 32'(i * 256);
        r_rw = 4'b1111;
        r_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_ch = 32'(t) % 4;
            n = 0;
            while (r_men !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (r_men !== 1'b1 || r_owner !== 3'(exp_ch) || r_maddr !== 32'(exp_ch * 256)) begin
                errors++;
                $display("FAIL rr_grant t=%0d men=%b owner=%0d maddr=%h want 1 %0d %h",
                         t, r_men, r_owner, r_maddr, exp_ch, exp_ch * 256);
            end
            r_mack = 1'b1;
            r_mdout = 32'hA000_0000 + 32'(t);
            @(negedge clk);
            r_mack = 1'b0;
            if (t == 4) r_req = '0;
            exp_ack = 4'b0001 << exp_ch;
            checks++;
            if (r_ack !== exp_ack || r_rdata !== 32'hA000_0000 + 32'(t)) begin
                errors++;
                $display("FAIL rr_ack t=%0d ack=%b rdata=%h want %b %h",
                         t, r_ack, r_rdata, exp_ack, 32'hA000_0000 + 32'(t));
            end
            @(negedge clk);
            checks++;
            if (r_ack !== 4'b0) begin
                errors++;
                $display("FAIL rr_ack_pulse t=%0d ack=%b want 0000", t, r_ack);
            end
        end
    endtask

    task automatic test_fixed_priority();
        f_addr[32*1 +: 32] = 32'h60;
        f_addr[32*2 +: 32] = 32'h80;
        f_wdata[W*2 +: W] = 32'h1234;
        f_rw = 4'b0010;
        f_req = 4'b0110;
        @(negedge clk);
        checks++;
        if (f_men !== 1'b1 || f_owner !== 3'd1 || f_maddr !== 32'h60 || f_mrw !== 1'b1) begin
            errors++;
            $display("FAIL fixed_first men=%b owner=%0d maddr=%h mrw=%b want 1 1 00000060 1",
                     f_men, f_owner, f_maddr, f_mrw);
        end
        f_mack = 1'b1;
        f_mdout = 32'h5555AAAA;
        @(negedge clk);
        f_mack = 1'b0;
        f_req[1] = 1'b0;
        checks++;
        if (f_ack !== 4'b0010 || f_rdata !== 32'h5555AAAA) begin
            errors++;
            $display("FAIL fixed_first_ack ack=%b rdata=%h want 0010 5555aaaa", f_ack, f_rdata);
        end
        @(negedge clk);
        checks++;
        if (f_men !== 1'b0 || f_ack !== 4'b0) begin
            errors++;
            $display("FAIL fixed_idle men=%b ack=%b want 0 0000", f_men, f_ack);
        end
        @(negedge clk);
        checks++;
        if (f_men !== 1'b1 || f_owner !== 3'd2 || f_maddr !== 32'h80 ||
            f_mrw !== 1'b0 || f_mdin !== 32'h1234) begin
            errors++;
            $display("FAIL fixed_write men=%b owner=%0d maddr=%h mrw=%b mdin=%h want 1 2 00000080 0 00001234",
                     f_men, f_owner, f_maddr, f_mrw, f_mdin);
        end
        f_mack = 1'b1;
        f_mdout = 32'hDEADBEEF;
        @(negedge clk);
        f_mack = 1'b0;
        f_req = '0;
        checks++;
        if (f_ack !== 4'b0100 || f_rdata !== 32'h5555AAAA) begin
            errors++;
            $display("FAIL fixed_write_ack ack=%b rdata=%h want 0100 5555aaaa", f_ack, f_rdata);
        end
    endtask

    task automatic test_reset_in_busy();
        r_addr[32*2 +: 32] = 32'h200;
        r_req = 4'b0100;
        @(negedge clk);
        checks++;
        if (r_men !== 1'b1 || r_owner !== 3'd2) begin
            errors++;
            $display("FAIL busy_pre_reset men=%b owner=%0d want 1 2", r_men, r_owner);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (r_men !== 1'b0 || r_ack !== 4'b0 || r_owner !== 3'd0) begin
            errors++;
            $display("FAIL async_reset men=%b ack=%b owner=%0d want 0 0000 0", r_men, r_ack, r_owner);
        end
        @(negedge clk);
        reset = 1'b1;
        r_req = 4'b1111;
        @(negedge clk);
        checks++;
        if (r_men !== 1'b1 || r_owner !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_grant men=%b owner=%0d want 1 0", r_men, r_owner);
        end
        r_mack = 1'b1;
        @(negedge clk);
        r_mack = 1'b0;
        r_req = '0;
        checks++;
        if (r_ack !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_ack ack=%b want 0001", r_ack);
        end
        @(negedge clk);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        r_rw = 4'b1000;
        r_req = 4'b1000;
        @(negedge clk);
        n = 0;
        while (r_men === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL timeout_cycles busy=%0d want 8", n);
        end
        checks++;
        if (r_ack !== 4'b1000 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_done ack=%b err=%b rdata=%h want 1000 1 00000000", r_ack, r_err, r_rdata);
        end
        r_req = '0;
        @(negedge clk);
        checks++;
        if (r_ack !== 4'b0 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse ack=%b err=%b want 0000 0", r_ack, r_err);
        end
    endtask
`else
    task automatic test_long_wait();
        int hold;
        r_rw = 4'b0010;
        r_addr[32*1 +: 32] = 32'h100;
        r_req = 4'b0010;
        @(negedge clk);
        hold = 0;
        for (int i = 0; i < 300; i++) begin
            if (r_men === 1'b1 && r_ack === 4'b0) hold++;
            @(negedge clk);
        end
        checks++;
        if (hold != 300) begin
            errors++;
            $display("FAIL long_wait_hold cycles=%0d want 300", hold);
        end
        r_mack = 1'b1;
        r_mdout = 32'h0BADF00D;
        @(negedge clk);
        r_mack = 1'b0;
        r_req = '0;
        checks++;
        if (r_ack !== 4'b0010 || r_err !== 1'b0 || r_rdata !== 32'h0BADF00D || r_men !== 1'b0) begin
            errors++;
            $display("FAIL long_wait_done ack=%b err=%b rdata=%h men=%b want 0010 0 0badf00d 0",
                     r_ack, r_err, r_rdata, r_men);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_rr_order();
        test_fixed_priority();
        test_reset_in_busy();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
